// File: rtl/mips_mdu_param.sv
// ---------------------------------------------------------------------------
// mips_mdu_param
//   Multiply/divide unit holding the architectural HI/LO registers for the
//   pipelined MIPS core. One operation is accepted per start pulse while idle.
//   Long operations (MULT/MULTU/DIV/DIVU, optionally MADD/MADDU) keep busy high
//   for MULT_CYCLES or DIV_CYCLES edges, then write HI/LO and pulse done.
//   MTHI/MTLO write HI/LO on the accepting edge without going busy.
//
//   Optional feature macro: MDU_MADD_EN
//     defined   : op 6 (MADD) / op 7 (MADDU) accumulate a*b into {hi,lo}
//     undefined : op 6 / op 7 are illegal and ignored
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset (aborts any operation)
//   start  in   operation request, accepted only when busy=0
//   op     in   0 MULT 1 MULTU 2 DIV 3 DIVU 4 MTHI 5 MTLO 6 MADD 7 MADDU
//   a, b   in   rs / rt operands (WIDTH bits)
//   busy   out  long operation in progress
//   done   out  one-cycle completion pulse of a long operation
//   hi, lo out  registered HI / LO
// ---------------------------------------------------------------------------
module mips_mdu_param #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAXC  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W = $clog2(MAXC + 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [WIDTH-1:0]   hi_q,    hi_d;
    logic [WIDTH-1:0]   lo_q,    lo_d;
    logic               done_q,  done_d;
    logic               wr_q,    wr_d;
    logic [2*WIDTH-1:0] res_q,   res_d;

    // Full 2*WIDTH product; sign- or zero-extending the operands first makes
    // the truncated unsigned product equal the signed product mod 2^(2*WIDTH).
    function automatic logic [2*WIDTH-1:0] mul_f(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic             sgn);
        logic [2*WIDTH-1:0] xe;
        logic [2*WIDTH-1:0] ye;
        xe = sgn ? {{WIDTH{x[WIDTH-1]}}, x} : {{WIDTH{1'b0}}, x};
        ye = sgn ? {{WIDTH{y[WIDTH-1]}}, y} : {{WIDTH{1'b0}}, y};
        return xe * ye;
    endfunction

    // Returns {remainder, quotient}. Signed division truncates toward zero and
    // the remainder follows the dividend. Dividing by -1 is done as a negation
    // so that most-negative / -1 wraps to itself with a zero remainder.
    function automatic logic [2*WIDTH-1:0] div_f(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic             sgn);
        logic signed [WIDTH-1:0] xs;
        logic signed [WIDTH-1:0] ys;
        logic signed [WIDTH-1:0] qs;
        logic signed [WIDTH-1:0] rs;
        logic        [WIDTH-1:0] qu;
        logic        [WIDTH-1:0] ru;
        xs = $signed(x);
        ys = $signed(y);
        qs = '0;
        rs = '0;
        qu = '0;
        ru = '0;
        if (y == '0) begin
            return '0;
        end else if (sgn && (y == '1)) begin
            return {{WIDTH{1'b0}}, '0 - x};
        end else if (sgn) begin
            qs = xs / ys;
            rs = xs % ys;
            return {rs, qs};
        end else begin
            qu = x / y;
            ru = x % y;
            return {ru, qu};
        end
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        wr_d    = wr_q;
        res_d   = res_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        3'd0, 3'd1: begin
                            state_d = S_RUN;
                            cnt_d   = CNT_W'(MULT_CYCLES - 1);
                            res_d   = mul_f(a, b, op == 3'd0);
                            wr_d    = 1'b1;
                        end
                        3'd2, 3'd3: begin
                            state_d = S_RUN;
                            cnt_d   = CNT_W'(DIV_CYCLES - 1);
                            res_d   = div_f(a, b, op == 3'd2);
                            // divide by zero still runs the full latency
                            // but leaves HI/LO untouched
                            wr_d    = (b != '0);
                        end
                        3'd4: hi_d = a;
                        3'd5: lo_d = a;
`ifdef MDU_MADD_EN
                        3'd6, 3'd7: begin
                            // {hi,lo} cannot change during RUN, so summing
                            // now equals summing at completion
                            state_d = S_RUN;
                            cnt_d   = CNT_W'(MULT_CYCLES - 1);
                            res_d   = {hi_q, lo_q} + mul_f(a, b, op == 3'd6);
                            wr_d    = 1'b1;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    if (wr_q) begin
                        {hi_d, lo_d} = res_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            wr_q    <= wr_d;
        end
    end

    // Pending result is pure data and only meaningful while RUN.
    always_ff @(posedge clk) begin
        res_q <= res_d;
    end

    assign busy = (state_q == S_RUN);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mips_mdu_param.sv
module tb_mips_mdu_param;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int total;
    int bad;

    // reference model state: event-scheduled, finish edge stored absolutely
    longint      edge_no;
    logic        m_busy;
    logic        m_done;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    longint      m_fin;
    logic        m_wr;
    logic [63:0] m_res;

    mips_mdu_param #(
        .WIDTH(32),
        .MULT_CYCLES(5),
        .DIV_CYCLES(10)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .op(op),
        .a(a),
        .b(b),
        .busy(busy),
        .done(done),
        .hi(hi),
        .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model(input logic r, input logic s, input logic [2:0] o,
                         input logic [31:0] aa, input logic [31:0] bb);
        longint sq;
        longint sr;
        bit [63:0] ua;
        bit [63:0] ub;
        if (r) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_hi   = '0;
            m_lo   = '0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                if (edge_no == m_fin) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    if (m_wr) {m_hi, m_lo} = m_res;
                end
            end else if (s) begin
                ua = {32'b0, aa};
                ub = {32'b0, bb};
                case (o)
                    3'd0: begin
                        m_res = 64'(longint'($signed(aa)) * longint'($signed(bb)));
                        m_wr = 1'b1; m_busy = 1'b1; m_fin = edge_no + 5;
                    end
                    3'd1: begin
                        m_res = ua * ub;
                        m_wr = 1'b1; m_busy = 1'b1; m_fin = edge_no + 5;
                    end
                    3'd2: begin
                        m_wr = (bb != 0);
                        if (bb != 0) begin
                            sq = longint'($signed(aa)) / longint'($signed(bb));
                            sr = longint'($signed(aa)) % longint'($signed(bb));
                            m_res = {sr[31:0], sq[31:0]};
                        end
                        m_busy = 1'b1; m_fin = edge_no + 10;
                    end
                    3'd3: begin
                        m_wr = (bb != 0);
                        if (bb != 0) m_res = {aa % bb, aa / bb};
                        m_busy = 1'b1; m_fin = edge_no + 10;
                    end
                    3'd4: m_hi = aa;
                    3'd5: m_lo = aa;
`ifdef MDU_MADD_EN
                    3'd6: begin
                        m_res = {m_hi, m_lo} + 64'(longint'($signed(aa)) * longint'($signed(bb)));
                        m_wr = 1'b1; m_busy = 1'b1; m_fin = edge_no + 5;
                    end
                    3'd7: begin
                        m_res = {m_hi, m_lo} + ua * ub;
                        m_wr = 1'b1; m_busy = 1'b1; m_fin = edge_no + 5;
                    end
`endif
                    default: ;
                endcase
            end
        end
        edge_no++;
    endtask

    task automatic cyc(input logic r, input logic s, input logic [2:0] o,
                       input logic [31:0] aa, input logic [31:0] bb);
        reset = r;
        start = s;
        op    = o;
        a     = aa;
        b     = bb;
        @(posedge clk);
        model(r, s, o, aa, bb);
        #1;
        chk("busy", 64'(busy), 64'(m_busy));
        chk("done", 64'(done), 64'(m_done));
        chk("hi", 64'(hi), 64'(m_hi));
        chk("lo", 64'(lo), 64'(m_lo));
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    endtask

    task automatic run_long(input string tag, input logic [2:0] o,
                            input logic [31:0] aa, input logic [31:0] bb, input int n_exp);
        int n;
        n = 0;
        cyc(1'b0, 1'b1, o, aa, bb);
        for (int i = 0; i < 40 && busy; i++) begin
            n++;
            idle();
        end
        chk({tag, "_len"}, 64'(n), 64'(n_exp));
        chk({tag, "_done1"}, 64'(done), 64'd1);
        idle();
        chk({tag, "_done0"}, 64'(done), 64'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        total   = 0;
        bad     = 0;
        edge_no = 0;
        m_busy  = 1'b0;
        m_done  = 1'b0;
        m_hi    = '0;
        m_lo    = '0;
        m_fin   = 0;
        m_wr    = 1'b0;
        m_res   = '0;

        cyc(1'b1, 1'b0, 3'd0, 32'h0, 32'h0);
        cyc(1'b1, 1'b1, 3'd0, 32'h5, 32'h5);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);

        run_long("mult", 3'd0, 32'hFFFFFFFD, 32'd7, 5);
        chk("mult_hi", 64'(hi), 64'hFFFFFFFF);
        chk("mult_lo", 64'(lo), 64'hFFFFFFEB);

        run_long("multu", 3'd1, 32'hFFFFFFFF, 32'd2, 5);
        chk("multu_hi", 64'(hi), 64'h1);
        chk("multu_lo", 64'(lo), 64'hFFFFFFFE);

        run_long("div", 3'd2, 32'hFFFFFFF9, 32'd2, 10);
        chk("div_lo", 64'(lo), 64'hFFFFFFFD);
        chk("div_hi", 64'(hi), 64'hFFFFFFFF);

        run_long("divmin", 3'd2, 32'h80000000, 32'hFFFFFFFF, 10);
        chk("divmin_lo", 64'(lo), 64'h80000000);
        chk("divmin_hi", 64'(hi), 64'h0);

        cyc(1'b0, 1'b1, 3'd4, 32'h12345678, 32'h0);
        chk("mthi", 64'(hi), 64'h12345678);
        run_long("divu0", 3'd3, 32'd7, 32'd0, 10);
        chk("divu0_hi", 64'(hi), 64'h12345678);
        chk("divu0_lo", 64'(lo), 64'h80000000);

        // starts during busy are dropped
        n = 0;
        cyc(1'b0, 1'b1, 3'd0, 32'd3, 32'd5);
        idle();
        cyc(1'b0, 1'b1, 3'd5, 32'hAAAA, 32'h0);
        cyc(1'b0, 1'b1, 3'd2, 32'd100, 32'd3);
        idle();
        chk("ign_busy4", 64'(busy), 64'd1);
        idle();
        chk("ign_busy5", 64'(busy), 64'd0);
        chk("ign_done", 64'(done), 64'd1);
        chk("ign_hi", 64'(hi), 64'h0);
        chk("ign_lo", 64'(lo), 64'd15);
        idle();

        // reset aborts an in-flight divide
        cyc(1'b0, 1'b1, 3'd2, 32'd50, 32'd7);
        idle();
        idle();
        cyc(1'b1, 1'b0, 3'd0, 32'h0, 32'h0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hi", 64'(hi), 64'd0);
        chk("abort_lo", 64'(lo), 64'd0);
        for (int i = 0; i < 12; i++) begin
            idle();
            if (done) n++;
        end
        chk("abort_nodone", 64'(n), 64'd0);
        run_long("mul34", 3'd0, 32'd3, 32'd4, 5);
        chk("mul34_lo", 64'(lo), 64'd12);
        chk("mul34_hi", 64'(hi), 64'd0);

        cyc(1'b0, 1'b1, 3'd5, 32'd10, 32'h0);
        cyc(1'b0, 1'b1, 3'd4, 32'd0, 32'h0);
`ifdef MDU_MADD_EN
        run_long("madd", 3'd6, 32'd3, 32'd4, 5);
        chk("madd_lo", 64'(lo), 64'd22);
        chk("madd_hi", 64'(hi), 64'd0);
        run_long("maddu", 3'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 5);
        chk("maddu_hilo", {hi, lo}, 64'hFFFFFFFE_00000017);
`else
        n = 0;
        cyc(1'b0, 1'b1, 3'd6, 32'd3, 32'd4);
        for (int i = 0; i < 8; i++) begin
            if (busy || done) n++;
            idle();
        end
        chk("madd_off_busy", 64'(n), 64'd0);
        chk("madd_off_lo", 64'(lo), 64'd10);
        chk("madd_off_hi", 64'(hi), 64'd0);
`endif

        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 2) == 0),
                3'($urandom_range(0, 7)), pick(), pick());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
